// File: rtl/sparse_fetch_scheduler.sv
// sparse_fetch_scheduler: round-robin SRAM fetch sequencer feeding the A/B decoder streams.
// Optional build macro: SPARSE_SCHED_DONE_TAG_EN rewrites each word's done bit to mark a stream's final word.
package sparse_sched_pkg;
    typedef struct packed {
        logic        done;
        logic        skip;
        logic [15:0] value;
    } sram_data_t;
endpackage

module sparse_fetch_scheduler
    import sparse_sched_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int CREDITS = 4
) (
    input  logic              mac_clk,
    input  logic              mac_rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] a_base_i,
    input  logic [ADDR_W-1:0] b_base_i,
    input  logic [ADDR_W:0]   a_len_i,
    input  logic [ADDR_W:0]   b_len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              sram_re_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  sram_data_t        sram_rdata_i,
    output logic              a_valid_o,
    output logic              b_valid_o,
    input  logic              a_ready_i,
    input  logic              b_ready_i,
    output sram_data_t        a_data_o,
    output sram_data_t        b_data_o
);
    localparam int CW = $clog2(CREDITS);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t            r_state;
    logic              r_busy, r_done, r_pri, r_ret_vld, r_ret_b;
`ifdef SPARSE_SCHED_DONE_TAG_EN
    logic              r_ret_last;
`endif
    logic [ADDR_W-1:0] r_ptr [2];
    logic [ADDR_W:0]   r_rem [2];
    logic [1:0]        r_infl;
    sram_data_t        r_mem [2][CREDITS];
    logic [CW-1:0]     r_wp [2], r_rp [2];
    logic [CW:0]       r_cnt [2], w_cnt_n [2];
    logic [ADDR_W-1:0] w_base [2];
    logic [ADDR_W:0]   w_len [2];
    logic [1:0]        w_ready, w_valid, w_pop, w_push, w_elig, w_gnt;
    logic              w_start, w_src_idle, w_fin;
    sram_data_t        w_wdata;

    // per-stream FIFO occupancy, eligibility and round-robin grant
    always_comb begin
        w_ready   = {b_ready_i, a_ready_i};
        w_base[0] = a_base_i;
        w_base[1] = b_base_i;
        w_len[0]  = a_len_i;
        w_len[1]  = b_len_i;
        for (int i = 0; i < 2; i++) begin
            w_valid[i] = r_cnt[i] != '0;
            w_pop[i]   = w_valid[i] & w_ready[i];
            w_push[i]  = r_ret_vld & (r_ret_b == 1'(i));
            w_elig[i]  = (r_state == FETCH) && (r_rem[i] != '0) &&
                         (({1'b0, r_cnt[i]} + {{(CW+1){1'b0}}, r_infl[i]}) < (CW+2)'(CREDITS));
            w_cnt_n[i] = r_cnt[i] + (CW+1)'(w_push[i]) - (CW+1)'(w_pop[i]);
        end
        w_gnt[0]   = w_elig[0] & (~w_elig[1] | ~r_pri);
        w_gnt[1]   = w_elig[1] & (~w_elig[0] | r_pri);
        w_start    = start_i & (r_state == IDLE);
        w_src_idle = (r_rem[0] == '0) && (r_rem[1] == '0) && (r_infl == '0);
        w_fin      = w_src_idle && (w_cnt_n[0] == '0) && (w_cnt_n[1] == '0);
    end

    // returned word, optionally retagged with the end-of-stream marker
    always_comb begin
        w_wdata = sram_rdata_i;
`ifdef SPARSE_SCHED_DONE_TAG_EN
        w_wdata.done = r_ret_last;
`endif
    end

    // job FSM, priority pointer and issue-to-return bookkeeping
    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pri     <= 1'b0;
            r_ret_vld <= 1'b0;
            r_ret_b   <= 1'b0;
`ifdef SPARSE_SCHED_DONE_TAG_EN
            r_ret_last <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_ret_vld <= |w_gnt;
            r_ret_b   <= w_gnt[1];
`ifdef SPARSE_SCHED_DONE_TAG_EN
            r_ret_last <= w_gnt[1] ? (r_rem[1] == (ADDR_W+1)'(1)) : (r_rem[0] == (ADDR_W+1)'(1));
`endif
            if (|w_gnt) r_pri <= w_gnt[0];
            if (w_start) begin
                r_state <= FETCH;
                r_busy  <= 1'b1;
                r_pri   <= 1'b0;
            end else if (r_state != IDLE && w_fin) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
            end else if (r_state == FETCH && w_src_idle) begin
                r_state <= DRAIN;
            end
        end
    end

    // address/remaining counters, in-flight flags and FIFO pointers
    always_ff @(posedge mac_clk or negedge mac_rst) begin
        if (!mac_rst) begin
            r_infl <= '0;
            for (int i = 0; i < 2; i++) begin
                r_ptr[i] <= '0;
                r_rem[i] <= '0;
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_start) begin
                    r_ptr[i] <= w_base[i];
                    r_rem[i] <= w_len[i];
                end else if (w_gnt[i]) begin
                    r_ptr[i] <= r_ptr[i] + ADDR_W'(1);
                    r_rem[i] <= r_rem[i] - (ADDR_W+1)'(1);
                end
                r_infl[i] <= w_gnt[i] | (r_infl[i] & ~w_push[i]);
                if (w_push[i]) r_wp[i] <= r_wp[i] + 1'b1;
                if (w_pop[i]) r_rp[i] <= r_rp[i] + 1'b1;
                r_cnt[i] <= w_cnt_n[i];
            end
        end
    end

    // FIFO storage; contents are only observed through the valid-gated outputs
    always_ff @(posedge mac_clk) begin
        for (int i = 0; i < 2; i++)
            if (w_push[i]) r_mem[i][r_wp[i]] <= w_wdata;
    end

    // credits must make a push into a full FIFO impossible
    always @(posedge mac_clk) begin
        if (mac_rst)
            for (int i = 0; i < 2; i++)
                assert (!(w_push[i] && !w_pop[i] && r_cnt[i] == (CW+1)'(CREDITS)));
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign sram_re_o   = |w_gnt;
    assign sram_addr_o = w_gnt[1] ? r_ptr[1] : (w_gnt[0] ? r_ptr[0] : '0);
    assign a_valid_o   = w_valid[0];
    assign b_valid_o   = w_valid[1];
    assign a_data_o    = w_valid[0] ? r_mem[0][r_rp[0]] : '0;
    assign b_data_o    = w_valid[1] ? r_mem[1][r_rp[1]] : '0;
endmodule

// File: tb/tb_sparse_fetch_scheduler.sv
// tb_sparse_fetch_scheduler: directed checks of fetch order, credits, wrap, restart and done tagging.
module tb_sparse_fetch_scheduler;
    import sparse_sched_pkg::*;
    localparam int AW = 10;
`ifdef SPARSE_SCHED_DONE_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif
    logic          mac_clk = 1'b0, mac_rst = 1'b0, start_i = 1'b0;
    logic [AW-1:0] a_base_i = '0, b_base_i = '0;
    logic [AW:0]   a_len_i = '0, b_len_i = '0;
    logic          busy_o, done_o, sram_re_o, a_valid_o, b_valid_o;
    logic          a_ready_i = 1'b1, b_ready_i = 1'b1;
    logic [AW-1:0] sram_addr_o;
    sram_data_t    sram_rdata_i = '0, a_data_o, b_data_o;
    int            n_chk = 0, n_fail = 0;
    logic [AW-1:0] q_addr [$];
    sram_data_t    q_a [$], q_b [$];
    int            kc, done_k, n_done, first_av;
    logic          b_seen, busy_k1, busy_at_done;

    sparse_fetch_scheduler #(.ADDR_W(AW), .CREDITS(4)) dut (
        .mac_clk(mac_clk), .mac_rst(mac_rst), .start_i(start_i),
        .a_base_i(a_base_i), .b_base_i(b_base_i), .a_len_i(a_len_i), .b_len_i(b_len_i),
        .busy_o(busy_o), .done_o(done_o), .sram_re_o(sram_re_o), .sram_addr_o(sram_addr_o),
        .sram_rdata_i(sram_rdata_i), .a_valid_o(a_valid_o), .b_valid_o(b_valid_o),
        .a_ready_i(a_ready_i), .b_ready_i(b_ready_i), .a_data_o(a_data_o), .b_data_o(b_data_o)
    );

    always #5 mac_clk = ~mac_clk;

    function automatic sram_data_t mk(input logic [AW-1:0] ad);
        sram_data_t w;
        w.done  = ad[1];
        w.skip  = ad[0];
        w.value = 16'(ad) * 16'd3 + 16'h0100;
        return w;
    endfunction

    function automatic sram_data_t ex(input logic [AW-1:0] ad, input logic last);
        sram_data_t w;
        w = mk(ad);
        w.done = TAG ? last : ad[1];
        return w;
    endfunction

    // one-cycle-latency SRAM model
    always @(posedge mac_clk) sram_rdata_i <= sram_re_o ? mk(sram_addr_o) : '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge mac_clk);
        #1;
    endtask

    task automatic go(input logic [AW-1:0] ab, input logic [AW:0] al, input logic [AW-1:0] bb, input logic [AW:0] bl);
        a_base_i = ab; a_len_i = al; b_base_i = bb; b_len_i = bl; start_i = 1'b1;
        q_addr.delete(); q_a.delete(); q_b.delete();
        kc = 0; done_k = -1; n_done = 0; first_av = -1; b_seen = 1'b0; busy_k1 = 1'b0; busy_at_done = 1'b1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            if (sram_re_o) q_addr.push_back(sram_addr_o);
            if (a_valid_o && first_av < 0) first_av = kc;
            if (a_valid_o && a_ready_i) q_a.push_back(a_data_o);
            if (b_valid_o && b_ready_i) q_b.push_back(b_data_o);
            if (b_valid_o) b_seen = 1'b1;
            if (kc == 1) busy_k1 = busy_o;
            if (done_o) begin n_done++; done_k = kc; busy_at_done = busy_o; end
            step();
            start_i = 1'b0;
            kc++;
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_ctl"}, {27'd0, busy_o, done_o, sram_re_o, a_valid_o, b_valid_o}, 32'd0);
        chk({tag, "_addr"}, 32'(sram_addr_o), 32'd0);
        chk({tag, "_data"}, {14'd0, a_data_o} | {14'd0, b_data_o}, 32'd0);
    endtask

    initial begin
        logic [AW-1:0] e1 [6];
        logic [AW-1:0] e3 [4];
        int nb;
        e1 = '{10'h010, 10'h100, 10'h011, 10'h101, 10'h012, 10'h102};
        e3 = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        #12;
        chk_idle_outs("reset");
        step();
        mac_rst = 1'b1;
        step();

        go(10'h010, 11'd3, 10'h100, 11'd3);
        run(14);
        chk("t1_nreads", q_addr.size(), 6);
        for (int i = 0; i < 6; i++) chk("t1_addr", 32'(q_addr[i]), 32'(e1[i]));
        chk("t1_busy_t1", 32'(busy_k1), 1);
        chk("t1_first_valid", first_av, 3);
        chk("t1_na", q_a.size(), 3);
        chk("t1_nb", q_b.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_a_word", 32'(q_a[i]), 32'(ex(AW'(10'h010 + i), i == 2)));
            chk("t1_b_word", 32'(q_b[i]), 32'(ex(AW'(10'h100 + i), i == 2)));
        end
        chk("t1_done_cycle", done_k, 9);
        chk("t1_done_count", n_done, 1);
        chk("t1_busy_at_done", 32'(busy_at_done), 0);

        b_ready_i = 1'b0;
        go(10'h020, 11'd2, 10'h200, 11'd10);
        run(20);
        nb = 0;
        foreach (q_addr[i]) if (q_addr[i] >= 10'h200) nb++;
        chk("t2_b_reads_stalled", nb, 4);
        chk("t2_reads_stalled", q_addr.size(), 6);
        chk("t2_na", q_a.size(), 2);
        for (int i = 0; i < 2; i++) chk("t2_a_word", 32'(q_a[i]), 32'(ex(AW'(10'h020 + i), i == 1)));
        chk("t2_no_done_stalled", n_done, 0);
        chk("t2_busy_stalled", 32'(busy_o), 1);
        chk("t2_b_head", 32'(b_data_o), 32'(ex(10'h200, 1'b0)));
        b_ready_i = 1'b1;
        run(30);
        chk("t2_reads_total", q_addr.size(), 12);
        chk("t2_nb", q_b.size(), 10);
        for (int i = 0; i < 10; i++) chk("t2_b_word", 32'(q_b[i]), 32'(ex(AW'(10'h200 + i), i == 9)));
        chk("t2_done_count", n_done, 1);

        go(10'h3FE, 11'd4, 10'h155, 11'd0);
        run(12);
        chk("t3_nreads", q_addr.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_addr", 32'(q_addr[i]), 32'(e3[i]));
        chk("t3_na", q_a.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_a_word", 32'(q_a[i]), 32'(ex(e3[i], i == 3)));
        chk("t3_b_never_valid", 32'(b_seen), 0);
        chk("t3_done_cycle", done_k, 7);

        go(10'h040, 11'd2, 10'h240, 11'd2);
        run(2);
        a_base_i = 10'h0C0; a_len_i = 11'd5; b_base_i = 10'h2C0; b_len_i = 11'd5; start_i = 1'b1;
        run(14);
        chk("t4_nreads", q_addr.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t4_addr", 32'(q_addr[i]), 32'(i[0] ? AW'(10'h240 + i / 2) : AW'(10'h040 + i / 2)));
        chk("t4_na", q_a.size(), 2);
        chk("t4_done_cycle", done_k, 7);
        chk("t4_done_count", n_done, 1);

        go(10'h050, 11'd8, 10'h250, 11'd8);
        run(4);
        mac_rst = 1'b0;
        #1;
        chk_idle_outs("t4_midrst");
        step();
        mac_rst = 1'b1;
        step();
        go(10'h060, 11'd1, 10'h260, 11'd1);
        run(10);
        chk("t4_post_nreads", q_addr.size(), 2);
        chk("t4_post_addr0", 32'(q_addr[0]), 32'h060);
        chk("t4_post_addr1", 32'(q_addr[1]), 32'h260);
        chk("t4_post_na", q_a.size(), 1);
        chk("t4_post_nb", q_b.size(), 1);
        chk("t4_post_a", 32'(q_a[0]), 32'(ex(10'h060, 1'b1)));
        chk("t4_post_b", 32'(q_b[0]), 32'(ex(10'h260, 1'b1)));
        chk("t4_post_done_cycle", done_k, 5);

        go(10'h072, 11'd3, 10'h300, 11'd0);
        run(10);
        chk("t5_na", q_a.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t5_word", 32'(q_a[i]), 32'(ex(AW'(10'h072 + i), i == 2)));
            chk("t5_done_bit", 32'(q_a[i].done), TAG ? 32'(i == 2) : 32'(i < 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
